// File: rtl/pll_pkg.sv
// Shared definitions for the PLL lock monitor: FSM encoding, default parameters
// and small helpers used by the monitor and its synchronizer.
package pll_pkg;

  typedef enum logic [1:0] {
    ST_PLLRST    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } pll_state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_PLLRST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT  = 65536;
  localparam int DEF_STABLE_CYCLES = 1024;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit; depth is clamped to at
// least two stages so a misconfigured instance never degrades to a bare flop.
module sync_ff
  import pll_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clkin,
  input  logic resetn,
  input  logic d,
  output logic q
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    logic stage_reg;
    if (gi == 0) begin : g_first
      always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) stage_reg <= 1'b0;
        else         stage_reg <= d;
      end
    end else begin : g_next
      always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) stage_reg <= 1'b0;
        else         stage_reg <= g_stage[gi-1].stage_reg;
      end
    end
  end

  assign q = g_stage[N-1].stage_reg;

endmodule

// File: rtl/pll_lock_monitor.sv
// Sequences PLL reset, qualifies lock for a stable period, and holds downstream
// logic in reset whenever the PLL cannot be trusted.
module pll_lock_monitor
  import pll_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int PLLRST_CYCLES = DEF_PLLRST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_resetn,
  output logic       lock_lost,
  output logic [7:0] relock_count,
  output logic [7:0] timeout_count,
  output logic [1:0] state
);

  localparam int CNT_W = $clog2(max3(PLLRST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLLRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  logic             lock_s;
  pll_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             pll_rst_reg;
  logic             sys_resetn_reg;
  logic             lock_lost_reg;
  logic [7:0]       relock_reg;
  logic [7:0]       timeout_reg;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clkin (clkin),
    .resetn(resetn),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // One shared counter; every transition below clears it in the same cycle.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_PLLRST;
      cnt_reg        <= '0;
      pll_rst_reg    <= 1'b1;
      sys_resetn_reg <= 1'b0;
      lock_lost_reg  <= 1'b0;
      relock_reg     <= 8'd0;
      timeout_reg    <= 8'd0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
      case (state_reg)
        ST_PLLRST: begin
          if (cnt_reg == PLLRST_LAST) begin
            state_reg   <= ST_WAIT_LOCK;
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b0;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock takes priority over a timeout landing in the same cycle.
          if (lock_s) begin
            state_reg <= ST_STABLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_reg   <= ST_PLLRST;
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b1;
            timeout_reg <= sat_inc8(timeout_reg);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_reg <= ST_WAIT_LOCK;
            cnt_reg   <= '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg      <= ST_RUN;
            cnt_reg        <= '0;
            sys_resetn_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          cnt_reg <= '0;
          if (!lock_s) begin
            state_reg      <= ST_WAIT_LOCK;
            sys_resetn_reg <= 1'b0;
            lock_lost_reg  <= 1'b1;
            relock_reg     <= sat_inc8(relock_reg);
          end
        end
        default: begin
          state_reg      <= ST_PLLRST;
          cnt_reg        <= '0;
          pll_rst_reg    <= 1'b1;
          sys_resetn_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst       = pll_rst_reg;
  assign sys_resetn    = sys_resetn_reg;
  assign lock_lost     = lock_lost_reg;
  assign relock_count  = relock_reg;
  assign timeout_count = timeout_reg;
  assign state         = state_reg;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Scoreboard bench: stimulus queues expected state transitions (with dwell time
// in the state being left); a negedge monitor pops and compares on each change.
module tb_pll_lock_monitor;

  localparam int PLLRST_CYCLES = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int STABLE_CYCLES = 8;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] dwell;
    logic       prst;
    logic       sysr;
    logic       ll;
    logic [7:0] rel;
    logic [7:0] tmo;
  } rec_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_resetn;
  logic       lock_lost;
  logic [7:0] relock_count;
  logic [7:0] timeout_count;
  logic [1:0] state;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;
  rec_t exp_q[$];

  pll_lock_monitor #(
    .SYNC_STAGES  (2),
    .PLLRST_CYCLES(PLLRST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clkin        (clk),
    .resetn       (resetn),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_resetn   (sys_resetn),
    .lock_lost    (lock_lost),
    .relock_count (relock_count),
    .timeout_count(timeout_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic push(input int st, input int dwell, input bit prst, input bit sysr,
                      input bit ll, input int rel, input int tmo);
    rec_t r;
    r.st = 2'(st); r.dwell = 8'(dwell); r.prst = prst; r.sysr = sysr;
    r.ll = ll; r.rel = 8'(rel); r.tmo = 8'(tmo);
    exp_q.push_back(r);
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 2000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: %0d transitions still pending, expected 0", name, exp_q.size());
    end
  endtask

  // Monitor: dwell counts negedges observed in the state being left.
  initial begin : monitor
    logic [1:0] prev;
    int         dwell;
    rec_t       act;
    rec_t       want;
    prev  = 2'd0;
    dwell = 0;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        prev  = 2'd0;
        dwell = 0;
      end else if (state === prev) begin
        dwell++;
      end else begin
        act.st = state; act.dwell = 8'(dwell); act.prst = pll_rst; act.sysr = sys_resetn;
        act.ll = lock_lost; act.rel = relock_count; act.tmo = timeout_count;
        n_checks++;
        n_txn++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL txn%0d unexpected: got st=%0d dwell=%0d, expected no transition",
                   n_txn, act.st, act.dwell);
        end else begin
          want = exp_q.pop_front();
          if (act !== want) begin
            n_fail++;
            $display("FAIL txn%0d: got st=%0d dwell=%0d prst=%0d sysr=%0d ll=%0d rel=%0d tmo=%0d, expected st=%0d dwell=%0d prst=%0d sysr=%0d ll=%0d rel=%0d tmo=%0d",
                     n_txn, act.st, act.dwell, act.prst, act.sysr, act.ll, act.rel, act.tmo,
                     want.st, want.dwell, want.prst, want.sysr, want.ll, want.rel, want.tmo);
          end else begin
            $display("txn%0d: st=%0d dwell=%0d prst=%0d sysr=%0d ll=%0d rel=%0d tmo=%0d ok",
                     n_txn, act.st, act.dwell, act.prst, act.sysr, act.ll, act.rel, act.tmo);
          end
        end
        prev  = state;
        dwell = 1;
      end
    end
  end

  initial begin : stimulus
    int rel;
    resetn     = 1'b1;
    pll_locked = 1'b0;
    #3 resetn  = 1'b0;
    step(2);
    check_val("rst_state", {6'd0, state}, 8'd0);
    check_val("rst_pll_rst", {7'd0, pll_rst}, 8'd1);
    check_val("rst_sys_resetn", {7'd0, sys_resetn}, 8'd0);
    check_val("rst_lock_lost", {7'd0, lock_lost}, 8'd0);
    check_val("rst_relock", relock_count, 8'd0);
    check_val("rst_timeout", timeout_count, 8'd0);

    // Cold start, RUN loss and STABLE glitch; times are posedges after release (P0).
    resetn = 1'b1;
    push(1, 4, 0, 0, 0, 0, 0);
    push(2, 9, 0, 0, 0, 0, 0);
    push(3, 8, 0, 1, 0, 0, 0);
    push(1, 12, 0, 0, 1, 1, 0);
    push(2, 5, 0, 0, 1, 1, 0);
    push(1, 7, 0, 0, 1, 1, 0);
    push(2, 1, 0, 0, 1, 1, 0);
    push(3, 8, 0, 1, 1, 1, 0);
    step(10); pll_locked = 1'b1;
    step(20); pll_locked = 1'b0;
    step(5);  pll_locked = 1'b1;
    step(7);  pll_locked = 1'b0;
    step(1);  pll_locked = 1'b1;
    step(11);

    // 300 one-cycle lock losses from RUN, each requalified before the next.
    for (int i = 1; i <= 300; i++) begin
      rel = (i + 1 > 255) ? 255 : i + 1;
      push(1, 4, 0, 0, 1, rel, 0);
      push(2, 1, 0, 0, 1, rel, 0);
      push(3, 8, 0, 1, 1, rel, 0);
      step(1);  pll_locked = 1'b0;
      step(1);  pll_locked = 1'b1;
      step(11);
    end
    drain("relock");
    check_val("sat_relock", relock_count, 8'd255);
    check_val("sat_lock_lost", {7'd0, lock_lost}, 8'd1);
    check_val("run_state", {6'd0, state}, 8'd3);

    // Asynchronous reset from RUN, sampled before the next clock edge.
    #1 resetn = 1'b0;
    #1;
    check_val("async_state", {6'd0, state}, 8'd0);
    check_val("async_pll_rst", {7'd0, pll_rst}, 8'd1);
    check_val("async_sys_resetn", {7'd0, sys_resetn}, 8'd0);
    check_val("async_lock_lost", {7'd0, lock_lost}, 8'd0);
    check_val("async_relock", relock_count, 8'd0);
    check_val("async_timeout", timeout_count, 8'd0);

    // Two lock timeouts, then lock arriving exactly on the third timeout cycle.
    pll_locked = 1'b0;
    step(3);
    resetn = 1'b1;
    push(1, 4, 0, 0, 0, 0, 0);
    push(0, 32, 1, 0, 0, 0, 1);
    push(1, 4, 0, 0, 0, 0, 1);
    push(0, 32, 1, 0, 0, 0, 2);
    push(1, 4, 0, 0, 0, 0, 2);
    push(2, 32, 0, 0, 0, 0, 2);
    push(3, 8, 0, 1, 0, 0, 2);
    step(105); pll_locked = 1'b1;
    drain("timeout");
    check_val("final_timeout", timeout_count, 8'd2);
    check_val("final_relock", relock_count, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for pll_locked (minimum 2).
REQ-002 SHALL have parameter PLLRST_CYCLES, default 16, width of the pll_rst pulse in clkin cycles.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65536, cycles allowed in WAIT_LOCK before re-issuing pll_rst.
REQ-004 SHALL have parameter STABLE_CYCLES, default 1024, continuous synchronized-lock cycles required before sys_resetn is released.
REQ-005 SHALL have port clkin, input, 1, the 25 MHz board reference clock, which is never a PLL output; this clock is the only clock.
REQ-006 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port pll_locked, input, 1, PLL LOCK output, asynchronous to clkin.
REQ-008 SHALL have port pll_rst, output, 1, active-high reset to the PLL RST pin.
REQ-009 SHALL have port sys_resetn, output, 1, active-low reset for downstream logic; it is asserted while the PLL is not trusted.
REQ-010 SHALL have port lock_lost, output, 1, sticky flag set on loss of lock in RUN; cleared only by resetn.
REQ-011 SHALL have port relock_count, output, 8, number of lock losses from RUN; saturates at 255.
REQ-012 SHALL have port timeout_count, output, 8, number of WAIT_LOCK timeouts; saturates at 255.
REQ-013 SHALL have port state, output, 2, current FSM state encoding, for debug.

Function
REQ-014 SHALL pass pll_locked through a SYNC_STAGES flip-flop chain; all decisions SHALL use only the last stage (lock_s).
REQ-015 SHALL implement FSM states PLLRST=0, WAIT_LOCK=1, STABLE=2 and RUN=3.
REQ-016 PLLRST SHALL drive pll_rst=1 for exactly PLLRST_CYCLES cycles, then go to WAIT_LOCK; lock_s is ignored in PLLRST.
REQ-017 WAIT_LOCK: if lock_s=1, go to STABLE; otherwise, after LOCK_TIMEOUT cycles, go to PLLRST and increment timeout_count.
REQ-018 STABLE: if lock_s=0 in any cycle, return to WAIT_LOCK with the counter cleared; after STABLE_CYCLES consecutive lock_s=1 cycles, go to RUN.
REQ-019 RUN: sys_resetn=1; if lock_s=0, go to WAIT_LOCK, set lock_lost, increment relock_count, and drive sys_resetn=0 in the same cycle as the transition.
REQ-020 sys_resetn SHALL be a registered output; it is 1 only in RUN, so the first 1 appears on the cycle the state register becomes RUN.
REQ-021 pll_rst SHALL be a registered output; it is 1 only in PLLRST.
REQ-022 A single shared cycle counter SHALL be used; it is cleared on every state change; its width is clog2 of the maximum of (PLLRST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) plus 1.
REQ-023 When a WAIT_LOCK timeout and lock_s=1 occur in the same cycle, lock_s SHALL win: go to STABLE and do not increment timeout_count.
REQ-024 Saturated counters SHALL hold at 255 and never wrap.
REQ-025 Glitches on lock_s shorter than one cycle in STABLE SHALL still restart the qualification; no filtering beyond the synchronizer.

Reset
REQ-026 On resetn=0, asynchronously: state=PLLRST, pll_rst=1, sys_resetn=0, lock_lost=0, both counts=0, counter=0, synchronizer=0.
REQ-027 After resetn deasserts, the first PLLRST period SHALL last PLLRST_CYCLES full cycles.
REQ-028 resetn asserted mid-operation (any state) SHALL immediately force the REQ-026 values.

Structure
REQ-029 The state encoding and the default parameter values SHALL live in the shared package pll_pkg.
REQ-030 The synchronizer SHALL be the sub-module sync_ff (parameter STAGES, ports clkin, resetn, d, q); it is reusable for other CDC bits.

Verification
REQ-031 Cold start with PLLRST_CYCLES=4, STABLE_CYCLES=8, and pll_locked rising 10 cycles after reset: pll_rst=1 for 4 cycles; sys_resetn rises 8 cycles after lock_s rises; state sequence 0,1,2,3.
REQ-032 Lock never asserts with LOCK_TIMEOUT=32: pll_rst re-pulses every 4+32 cycles; timeout_count increments each time; sys_resetn stays 0.
REQ-033 In STABLE, pll_locked drops for 1 cycle at count 5: return to WAIT_LOCK; a full 8 cycles are required again; relock_count is unchanged.
REQ-034 In RUN, pll_locked drops: sys_resetn=0 within SYNC_STAGES+1 cycles; lock_lost=1; relock_count=1; sys_resetn is re-released after requalification.
REQ-035 Force 300 lock losses: relock_count holds at 255; lock_lost stays 1.
REQ-036 Assert resetn in RUN: all outputs take their reset values asynchronously before the next clkin edge.
